// File: rtl/tanh_series_engine.sv
// tanh_series_engine: iterative odd-power series evaluator.
//   Y = sum_{k<NTERMS} s_k * c_k * X^(2k+1), one multiply-accumulate step per clock.
//   mode_i = 0 selects tanh coefficients with alternating signs.
//   mode_i = 1 selects sinh coefficients 1/(2k+1)!, all positive.
// Ports:
//   clk_i, rst_i  rising-edge clock, synchronous active-high reset
//   start_i       request, sampled only while idle
//   x_in_i        signed Q(W-FRAC).FRAC operand
//   mode_i        series select
//   busy_o        evaluation in progress (SQR, ACC and DONE cycles)
//   done_o        one-cycle pulse; y_out_o is valid from this cycle
//   y_out_o       saturated result, held until the next done
//   ovf_o         saturation occurred while producing y_out_o
module tanh_series_engine #(
  parameter int unsigned W      = 16,
  parameter int unsigned FRAC   = 12,
  parameter int unsigned NTERMS = 4,
  parameter int unsigned AW     = W + 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic signed [W-1:0] x_in_i,
  input  logic                mode_i,
  output logic                busy_o,
  output logic                done_o,
  output logic signed [W-1:0] y_out_o,
  output logic                ovf_o
);

  localparam int unsigned W2 = 2 * W;

  // round(num/den * 2^FRAC), evaluated at elaboration only
  function automatic longint rnd_coef(input longint num, input longint den);
    return ((num <<< (FRAC + 1)) + den) / (2 * den);
  endfunction

  localparam logic signed [W-1:0] CoefTanh [8] = '{
    W'(rnd_coef(1, 1)), W'(rnd_coef(1, 3)), W'(rnd_coef(2, 15)), W'(rnd_coef(17, 315)),
    W'(rnd_coef(62, 2835)), W'(rnd_coef(1382, 155925)), '0, '0
  };
  localparam logic signed [W-1:0] CoefSinh [8] = '{
    W'(rnd_coef(1, 1)), W'(rnd_coef(1, 6)), W'(rnd_coef(1, 120)), W'(rnd_coef(1, 5040)),
    W'(rnd_coef(1, 362880)), W'(rnd_coef(1, 39916800)), '0, '0
  };

  // Returns {overflow, clamped value}
  function automatic logic [W:0] sat_w(input logic signed [W2-1:0] v);
    if (&v[W2-1:W-1] || ~|v[W2-1:W-1]) return {1'b0, v[W-1:0]};
    else if (v[W2-1])                  return {1'b1, 1'b1, {(W-1){1'b0}}};
    else                               return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  function automatic logic [W:0] sat_acc(input logic signed [AW-1:0] v);
    if (&v[AW-1:W-1] || ~|v[AW-1:W-1]) return {1'b0, v[W-1:0]};
    else if (v[AW-1])                  return {1'b1, 1'b1, {(W-1){1'b0}}};
    else                               return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  typedef enum logic [1:0] {StIdle, StSqr, StAcc, StDone} state_e;

  state_e                state_q, state_d;
  logic signed [W-1:0]   xr_q, xr_d, sqr_q, sqr_d, term_q, term_d, y_q, y_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [2:0]            k_q, k_d;
  logic                  mr_q, mr_d, ovf_q, ovf_d, ovf_cand_q, ovf_cand_d;

  logic signed [W2-1:0]  sq_prod, tq_prod, ct_prod;
  logic signed [W-1:0]   coef;
  logic signed [AW-1:0]  ct_term, acc_sum;
  logic [W:0]            sq_sat, tq_sat, acc_sat;
  logic                  last_term;

  assign sq_prod   = W2'(xr_q) * W2'(xr_q);
  assign tq_prod   = W2'(term_q) * W2'(sqr_q);
  assign coef      = mr_q ? CoefSinh[k_q] : CoefTanh[k_q];
  assign ct_prod   = W2'(coef) * W2'(term_q);
  // |c_k * term| >> FRAC stays within W+1 bits, so AW holds it exactly
  assign ct_term   = AW'(ct_prod >>> FRAC);
  assign acc_sum   = (mr_q || !k_q[0]) ? acc_q + ct_term : acc_q - ct_term;
  assign sq_sat    = sat_w(sq_prod >>> FRAC);
  assign tq_sat    = sat_w(tq_prod >>> FRAC);
  assign acc_sat   = sat_acc(acc_sum);
  assign last_term = (k_q == 3'(NTERMS - 1));

  always_comb begin
    state_d    = state_q;
    xr_d       = xr_q;
    mr_d       = mr_q;
    sqr_d      = sqr_q;
    term_d     = term_q;
    acc_d      = acc_q;
    k_d        = k_q;
    y_d        = y_q;
    ovf_d      = ovf_q;
    ovf_cand_d = ovf_cand_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          xr_d    = x_in_i;
          mr_d    = mode_i;
          state_d = StSqr;
        end
      end
      StSqr: begin
        busy_o     = 1'b1;
        sqr_d      = sq_sat[W-1:0];
        term_d     = xr_q;
        acc_d      = '0;
        k_d        = '0;
        ovf_cand_d = sq_sat[W];
        state_d    = StAcc;
      end
      StAcc: begin
        busy_o = 1'b1;
        acc_d  = acc_sum;
        term_d = tq_sat[W-1:0];
        k_d    = k_q + 3'd1;
        // A term computed after the last step is never used, so it cannot flag overflow
        if (!last_term && tq_sat[W]) ovf_cand_d = 1'b1;
        if (last_term) begin
          // Result registered on entry to DONE so it is valid alongside the done pulse
          y_d     = acc_sat[W-1:0];
          ovf_d   = ovf_cand_q | acc_sat[W];
          state_d = StDone;
        end
      end
      StDone: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      xr_q       <= '0;
      mr_q       <= 1'b0;
      sqr_q      <= '0;
      term_q     <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      ovf_cand_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      xr_q       <= xr_d;
      mr_q       <= mr_d;
      sqr_q      <= sqr_d;
      term_q     <= term_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      y_q        <= y_d;
      ovf_q      <= ovf_d;
      ovf_cand_q <= ovf_cand_d;
    end
  end

  assign y_out_o = y_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_tanh_series_engine.sv
// Scoreboard bench for tanh_series_engine (W=16, FRAC=12, NTERMS=4).
// Stimulus pushes the expected result; a negedge monitor pops on every done pulse.
module tb_tanh_series_engine;

  localparam int W      = 16;
  localparam int FRAC   = 12;
  localparam int NTERMS = 4;
  localparam int LAT    = NTERMS + 1;  // edges from the accepting edge to the DONE cycle

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_out;
  logic               busy, done, ovf;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int y;
    int ref_y;
    int tol;
    bit ovf;
    int cyc;
  } exp_t;
  exp_t sb[$];

  tanh_series_engine #(.W(W), .FRAC(FRAC), .NTERMS(NTERMS), .AW(W + 4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .x_in_i  (x_in),
    .mode_i  (mode),
    .busy_o  (busy),
    .done_o  (done),
    .y_out_o (y_out),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint coef(input bit m, input int k);
    real a;
    if (m) begin
      real f = 1.0;
      for (int i = 2; i <= 2 * k + 1; i++) f = f * i;
      a = 1.0 / f;
    end else begin
      case (k)
        0: a = 1.0;
        1: a = 1.0 / 3.0;
        2: a = 2.0 / 15.0;
        3: a = 17.0 / 315.0;
        4: a = 62.0 / 2835.0;
        default: a = 1382.0 / 155925.0;
      endcase
    end
    return longint'($rtoi(a * 4096.0 + 0.5));
  endfunction

  function automatic longint clamp16(input longint v, inout bit f);
    if (v > 32767) begin f = 1'b1; return 32767; end
    if (v < -32768) begin f = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic void model(input int x, input bit m, output int y, output bit o);
    longint sq, t, acc, p;
    bit f = 1'b0;
    sq  = clamp16((longint'(x) * longint'(x)) >>> FRAC, f);
    t   = x;
    acc = 0;
    for (int k = 0; k < NTERMS; k++) begin
      p = (coef(m, k) * t) >>> FRAC;
      if (!m && (k % 2 == 1)) acc = acc - p;
      else acc = acc + p;
      if (k < NTERMS - 1) t = clamp16((t * sq) >>> FRAC, f);
    end
    y = int'(clamp16(acc, f));
    o = f;
  endfunction

  // ---------------- stimulus ----------------
  // tol < 0 skips the check against the independently known value ref_y
  task automatic start_run(input int x, input bit m, input bit push, input int ref_y,
                           input int tol);
    int   waited = 0;
    int   my;
    bit   mo;
    exp_t e;
    @(negedge clk);
    while (busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_wait: busy=1 after %0d cycles, required 0", waited);
    end
    start = 1'b1;
    x_in  = 16'(x);
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = 16'($urandom);  // must not disturb the run in flight
    mode  = 1'($urandom);
    if (push) begin
      model(x, m, my, mo);
      e.y     = my;
      e.ref_y = ref_y;
      e.tol   = tol;
      e.ovf   = mo;
      e.cyc   = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        check("y_out", int'(y_out), e.y);
        check("ovf", int'(ovf), int'(e.ovf));
        check("done_cycle", cyc, e.cyc);
        if (e.tol >= 0) begin
          n_chk++;
          d = int'(y_out) - e.ref_y;
          if (d > e.tol || d < -e.tol) begin
            n_fail++;
            $display("FAIL y_tolerance: got %0d, required %0d +/- %0d", y_out, e.ref_y, e.tol);
          end
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_y", int'(y_out), 0);
    check("reset_ovf", int'(ovf), 0);
    rst = 1'b0;

    // x=0 tanh, busy on cycles 1..6 only
    start_run(0, 1'b0, 1'b1, 0, 0);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check("busy_in_run", int'(busy), 1);
    end
    @(negedge clk);
    check("busy_after_run", int'(busy), 0);

    start_run(2048, 1'b0, 1'b1, 1893, 2);
    start_run(-2048, 1'b0, 1'b1, -1893, 2);
    start_run(4096, 1'b1, 1'b1, 4814, 2);
    start_run(32767, 1'b1, 1'b1, 32767, 0);
    start_run(0, 1'b0, 1'b1, 0, 0);

    // Starts at cycles 2 and 4 must be ignored
    start_run(1000, 1'b0, 1'b1, 0, -1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    x_in  = -16'sd5000;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    x_in  = 16'sd7000;
    mode  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    // Reset at cycle 3 aborts the run without a done pulse
    start_run(2048, 1'b0, 1'b1, 1893, 2);
    start_run(4096, 1'b1, 1'b0, 0, -1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_y", int'(y_out), 0);
    check("abort_ovf", int'(ovf), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    start_run(-2048, 1'b0, 1'b1, -1893, 2);

    // Randomised runs, mostly in the convergent range, some full-scale
    for (int i = 0; i < 30; i++) begin
      int x;
      if ($urandom_range(0, 1) == 0) x = int'($urandom_range(0, 12000)) - 6000;
      else x = int'($urandom_range(0, 65535)) - 32768;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_run(x, 1'($urandom_range(0, 1)), 1'b1, 0, -1);
    end

    w = 0;
    while (sb.size() > 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
